stch2dec_counter: RTL and testbench
===================================

Name: stch2dec_counter

Overview:
- Downstream partner of the decimal-to-stochastic converter. It turns a 1-bit stochastic stream S back into an ND-bit probability, scaled to x/2^ND.
- Counts the ones in S over a fixed window of 2^NW enabled cycles. At each window end it registers the result and presents it to the consumer with a VALID/ACK handshake.
- Used at network outputs and for monitoring intermediate neuron streams.

Parameters:
- ND, 8, output precision in bits (D is ND bits).
- NW, 8, log2 of window length in enabled cycles. Constraint: NW >= ND.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- INIT  in  1  synchronous, active-low reset (INIT=0 at posedge resets the block).
- EN  in  1  sample enable; S is counted only in cycles with EN=1.
- CLR  in  1  synchronous abort of the current partial window.
- S  in  1  stochastic bit stream.
- ACK  in  1  consumer accepts D (meaningful only while VALID=1).
- D  out  ND  decoded probability, or two's-complement bipolar value with STCH_BIPOLAR_EN.
- VALID  out  1  D holds an unconsumed result.
- OVR  out  1  sticky: a result was overwritten before it was acknowledged.

Behaviour:
- Reset (INIT=0 at posedge): state=IDLE, ones counter cnt=0 (NW+1 bits), index idx=0 (NW bits), D=0, VALID=0, OVR=0. Reset overrides all other inputs, including mid-window; the partial window is discarded.
- States: IDLE and ACC.
  - IDLE -> ACC on the first cycle with EN=1. That cycle's S is counted as sample 0.
  - ACC remains ACC across windows; back-to-back windows have no gap cycle.
  - ACC -> IDLE only on CLR=1 or reset.
- Counting in ACC: each cycle with EN=1 does cnt += S and idx += 1. Cycles with EN=0 freeze cnt and idx; the window is paused, not restarted.
- Window end: the enabled cycle with idx = 2^NW-1. In that cycle:
  - total = cnt + S (range 0..2^NW).
  - D <= min(total >> (NW-ND), 2^ND-1). All-ones saturates to 2^ND-1 and never wraps to 0.
  - VALID <= 1; cnt <= 0; idx <= 0 (wraps).
- Latency: D and VALID update on the same posedge that samples the last bit of the window. They are visible in the following cycle.
- Handshake:
  - ACK=1 while VALID=1 clears VALID at the next posedge.
  - D holds its value until the next window end; it is not cleared by ACK.
  - ACK while VALID=0 is ignored.
- Simultaneous window end and ACK: the new D is loaded and VALID stays 1. OVR is not set.
- Window end while VALID=1 and ACK=0: D is overwritten, VALID stays 1, OVR <= 1. OVR is sticky until reset.
- CLR=1:
  - cnt <= 0, idx <= 0, state <= IDLE; D, VALID and OVR are unchanged.
  - CLR has priority over a window end in the same cycle; that window is discarded.
  - CLR=1 together with EN=1 does not count S.
- Arithmetic: cnt is NW+1 bits wide, so it never overflows within a window.

Optional Feature:
- Macro: STCH_BIPOLAR_EN.
- Defined:
  - D is an ND-bit two's-complement value = clamp(scaled - 2^(ND-1), -2^(ND-1), 2^(ND-1)-1), where scaled = total >> (NW-ND) before saturation.
  - Examples with ND=8: all-ones gives 127, all-zeros gives -128, half ones gives 0.
  - Reset value of D is 0.
- Undefined: unipolar behaviour as described under Behaviour.
- Handshake, OVR and CLR behaviour are identical in both builds.

Test Plan:
- ND=NW=8, INIT low 2 cycles then high, EN=1, S=1 for 256 cycles -> D=255 and VALID=1 in cycle 257. S=0 for the next 256 cycles -> D=0.
- S alternating 1,0 for 256 cycles -> D=128. Hold ACK=0 through a second identical window -> OVR=1, D=128, VALID=1. Then pulse ACK -> VALID=0 next cycle, OVR stays 1.
- EN toggled 1,0 repeatedly with S=1 -> window completes after 512 clocks (256 enabled), D=255. Samples taken while EN=0 are not counted.
- INIT=0 at sample 100 of a window, then resume -> D=0, VALID=0, OVR=0. Next full window of 64 ones + 192 zeros -> D=64.
- CLR at sample 200, then 256 samples with S=1 -> D=255. CLR asserted in the window-end cycle -> no VALID pulse.
- With STCH_BIPOLAR_EN: all-ones -> D=8'h7F; all-zeros -> 8'h80; alternating -> 8'h00. Window end with simultaneous ACK -> VALID stays 1, OVR=0.

Source files
------------

// File: rtl/stch2dec_counter_if.sv
// -----------------------------------------------------------------------------
// stch2dec_counter_if
// Bundles the stream input, sample controls and the result handshake of the
// stochastic-to-decimal counter. The producer/consumer side uses the master
// modport; the counter itself uses the slave modport.
// -----------------------------------------------------------------------------
interface stch2dec_counter_if #(
    parameter int ND = 8
);
    logic          EN;     // sample enable
    logic          CLR;    // abort the current partial window
    logic          S;      // stochastic bit stream
    logic          ACK;    // consumer accepts D
    logic [ND-1:0] D;      // decoded value
    logic          VALID;  // D holds an unconsumed result
    logic          OVR;    // sticky overwrite flag

    modport master (
        output EN,
        output CLR,
        output S,
        output ACK,
        input  D,
        input  VALID,
        input  OVR
    );

    modport slave (
        input  EN,
        input  CLR,
        input  S,
        input  ACK,
        output D,
        output VALID,
        output OVR
    );
endinterface

// File: rtl/stch2dec_counter.sv
// -----------------------------------------------------------------------------
// stch2dec_counter
// Counts the ones of a stochastic stream over windows of 2^NW enabled cycles
// and presents each window's result, scaled to ND bits, through a
// VALID/ACK handshake. Back-to-back windows run without a gap cycle.
//
// Build option: define STCH_BIPOLAR_EN to present D as an ND-bit
// two's-complement bipolar value (scaled - 2^(ND-1), clamped). Without it,
// D is the unipolar value min(scaled, 2^ND-1).
// -----------------------------------------------------------------------------
module stch2dec_counter #(
    parameter int ND = 8,
    parameter int NW = 8
) (
    input  logic                 CLK,
    input  logic                 INIT,   // synchronous, active-low
    stch2dec_counter_if.slave    bus
);

    // The window must hold at least as many samples as D has codes.
    if (NW < ND) begin : g_param_check
        $error("stch2dec_counter: NW must be >= ND");
    end

    localparam int            SHIFT   = NW - ND;
    localparam logic [NW-1:0] IDX_MAX = '1;
    localparam logic [ND-1:0] D_MAX   = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t             r_state;
    logic signed [NW:0] r_cnt_unused_sign_guard; // never used; see below
    logic        [NW:0] r_cnt;     // ones seen so far in this window
    logic      [NW-1:0] r_idx;     // enabled samples taken in this window
    logic      [ND-1:0] r_d;
    logic               r_valid;
    logic               r_ovr;

    logic        [NW:0] w_total;
    logic               w_win_end;
    logic      [ND-1:0] w_d_next;

    // Unipolar scaled value of a window total; all-ones saturates instead of
    // wrapping to zero.
    function automatic logic [ND-1:0] sat_unipolar(input logic [NW:0] total);
        logic [NW:0] scaled;
        scaled = total >> SHIFT;
        if (scaled > {{(NW+1-ND){1'b0}}, D_MAX}) begin
            return D_MAX;
        end
        return scaled[ND-1:0];
    endfunction

`ifdef STCH_BIPOLAR_EN
    localparam logic signed [NW+1:0] BP_HALF = (NW+2)'(2**(ND-1));
    localparam logic signed [NW+1:0] BP_MAX  = BP_HALF - (NW+2)'(1);
    localparam logic signed [NW+1:0] BP_MIN  = -BP_HALF;

    // Bipolar value: scaled total re-centred on zero and clamped to the
    // ND-bit two's-complement range.
    function automatic logic [ND-1:0] decode(input logic [NW:0] total);
        logic        [NW:0]   scaled;
        logic signed [NW+1:0] centred;
        logic signed [NW+1:0] clamped;
        scaled  = total >> SHIFT;
        centred = $signed({1'b0, scaled}) - BP_HALF;
        if (centred > BP_MAX) begin
            clamped = BP_MAX;
        end else if (centred < BP_MIN) begin
            clamped = BP_MIN;
        end else begin
            clamped = centred;
        end
        return clamped[ND-1:0];
    endfunction
`else
    // Unipolar build: D is the saturated scaled total.
    function automatic logic [ND-1:0] decode(input logic [NW:0] total);
        return sat_unipolar(total);
    endfunction
`endif

    // Window total including the bit sampled this cycle, its decoded value,
    // and the window-end strobe (CLR discards the window).
    always_comb begin
        w_total   = r_cnt + (NW+1)'(bus.S);
        w_d_next  = decode(w_total);
        w_win_end = (r_state == S_ACC) && bus.EN && !bus.CLR
                    && (r_idx == IDX_MAX);
    end

    // Unused guard register kept constant so the signed declaration above
    // does not leave a floating state element.
    always_ff @(posedge CLK) begin
        r_cnt_unused_sign_guard <= '0;
    end

    // Control FSM, window counters and registered handshake outputs.
    always_ff @(posedge CLK) begin
        if (!INIT) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_d     <= '0;
            r_valid <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            // Consumer acknowledge; a simultaneous window end re-asserts
            // VALID below because the later assignment wins.
            if (r_valid && bus.ACK) begin
                r_valid <= 1'b0;
            end

            if (bus.CLR) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_idx   <= '0;
            end else if (bus.EN) begin
                case (r_state)
                    S_IDLE: begin
                        // This enabled cycle's bit is sample 0 of the window.
                        r_state <= S_ACC;
                        r_cnt   <= (NW+1)'(bus.S);
                        r_idx   <= NW'(1);
                    end
                    S_ACC: begin
                        if (w_win_end) begin
                            r_d     <= w_d_next;
                            r_valid <= 1'b1;
                            if (r_valid && !bus.ACK) begin
                                r_ovr <= 1'b1;
                            end
                            r_cnt   <= '0;
                            r_idx   <= '0;
                        end else begin
                            r_cnt   <= w_total;
                            r_idx   <= r_idx + NW'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.D     = r_d;
    assign bus.VALID = r_valid;
    assign bus.OVR   = r_ovr;

endmodule

// File: tb/tb_stch2dec_counter.sv
// -----------------------------------------------------------------------------
// tb_stch2dec_counter
// Directed bench for stch2dec_counter with ND = NW = 8 (256-sample windows).
// Expected D values are hand-computed for both the unipolar and the
// STCH_BIPOLAR_EN build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stch2dec_counter;

    localparam int ND = 8;
    localparam int NW = 8;

    logic CLK  = 1'b0;
    logic INIT = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    stch2dec_counter_if #(.ND(ND)) bus ();

    stch2dec_counter #(.ND(ND), .NW(NW)) dut (
        .CLK  (CLK),
        .INIT (INIT),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    // Pick the hand-computed expectation for the build under test.
    function automatic logic [ND-1:0] pick(input logic [ND-1:0] uni,
                                           input logic [ND-1:0] bip);
`ifdef STCH_BIPOLAR_EN
        return bip;
`else
        return uni;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // One clock; inputs change 1 ns after the edge, outputs are sampled there.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // n enabled samples; mode 0 = zeros, 1 = ones, 2 = alternating 1,0.
    task automatic feed(input int n, input int mode, input bit ack_first);
        for (int i = 0; i < n; i++) begin
            bus.EN  = 1'b1;
            bus.S   = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : (i % 2 == 0);
            bus.ACK = ack_first && (i == 0);
            tick();
        end
        bus.EN  = 1'b0;
        bus.S   = 1'b0;
        bus.ACK = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.EN  = 1'b0;
        bus.ACK = 1'b1;
        tick();
        bus.ACK = 1'b0;
    endtask

    initial begin
        bus.EN  = 1'b0;
        bus.CLR = 1'b0;
        bus.S   = 1'b0;
        bus.ACK = 1'b0;

        // Reset
        INIT = 1'b0;
        tick();
        tick();
        chk("rst_d",     32'(bus.D),     32'h0);
        chk("rst_valid", 32'(bus.VALID), 32'h0);
        chk("rst_ovr",   32'(bus.OVR),   32'h0);
        INIT = 1'b1;

        // All-ones window saturates
        feed(255, 1, 1'b0);
        chk("ones_early_valid", 32'(bus.VALID), 32'h0);
        feed(1, 1, 1'b0);
        chk("ones_d",     32'(bus.D),     32'(pick(8'hFF, 8'h7F)));
        chk("ones_valid", 32'(bus.VALID), 32'h1);
        chk("ones_ovr",   32'(bus.OVR),   32'h0);

        // ACK clears VALID, D holds; then all-zeros window
        feed(1, 0, 1'b1);
        chk("ack_valid", 32'(bus.VALID), 32'h0);
        chk("ack_d_hold", 32'(bus.D),    32'(pick(8'hFF, 8'h7F)));
        feed(255, 0, 1'b0);
        chk("zeros_d",     32'(bus.D),     32'(pick(8'h00, 8'h80)));
        chk("zeros_valid", 32'(bus.VALID), 32'h1);
        chk("zeros_ovr",   32'(bus.OVR),   32'h0);

        // Alternating window, then an unacknowledged second one
        feed(256, 2, 1'b1);
        chk("alt_d",     32'(bus.D),     32'(pick(8'h80, 8'h00)));
        chk("alt_valid", 32'(bus.VALID), 32'h1);
        chk("alt_ovr0",  32'(bus.OVR),   32'h0);
        feed(256, 2, 1'b0);
        chk("ovr_set",   32'(bus.OVR),   32'h1);
        chk("ovr_d",     32'(bus.D),     32'(pick(8'h80, 8'h00)));
        chk("ovr_valid", 32'(bus.VALID), 32'h1);
        ack_pulse();
        chk("ovr_ack_valid",  32'(bus.VALID), 32'h0);
        chk("ovr_sticky",     32'(bus.OVR),   32'h1);

        // EN toggling with S=1: 512 clocks for 256 enabled samples
        for (int i = 0; i < 510; i++) begin
            bus.EN = (i % 2 == 0);
            bus.S  = 1'b1;
            tick();
        end
        chk("en_tog_early_valid", 32'(bus.VALID), 32'h0);
        for (int i = 510; i < 512; i++) begin
            bus.EN = (i % 2 == 0);
            bus.S  = 1'b1;
            tick();
        end
        bus.EN = 1'b0;
        chk("en_tog_d",     32'(bus.D),     32'(pick(8'hFF, 8'h7F)));
        chk("en_tog_valid", 32'(bus.VALID), 32'h1);
        ack_pulse();

        // Ones only while EN=0 must not be counted
        for (int i = 0; i < 512; i++) begin
            bus.EN = (i % 2 == 0);
            bus.S  = !(i % 2 == 0);
            tick();
        end
        bus.EN = 1'b0;
        bus.S  = 1'b0;
        chk("en_gate_d",     32'(bus.D),     32'(pick(8'h00, 8'h80)));
        chk("en_gate_valid", 32'(bus.VALID), 32'h1);

        // Reset mid-window discards everything
        ack_pulse();
        feed(100, 1, 1'b0);
        INIT = 1'b0;
        tick();
        chk("mid_rst_d",     32'(bus.D),     32'h0);
        chk("mid_rst_valid", 32'(bus.VALID), 32'h0);
        chk("mid_rst_ovr",   32'(bus.OVR),   32'h0);
        INIT = 1'b1;
        feed(64, 1, 1'b0);
        feed(191, 0, 1'b0);
        chk("q64_early_valid", 32'(bus.VALID), 32'h0);
        feed(1, 0, 1'b0);
        chk("q64_d",     32'(bus.D),     32'(pick(8'h40, 8'hC0)));
        chk("q64_valid", 32'(bus.VALID), 32'h1);

        // CLR at sample 200, then a fresh full window
        ack_pulse();
        feed(200, 1, 1'b0);
        bus.CLR = 1'b1;
        bus.EN  = 1'b1;
        bus.S   = 1'b1;
        tick();
        bus.CLR = 1'b0;
        bus.EN  = 1'b0;
        chk("clr_valid", 32'(bus.VALID), 32'h0);
        feed(255, 1, 1'b0);
        chk("clr_early_valid", 32'(bus.VALID), 32'h0);
        feed(1, 1, 1'b0);
        chk("clr_full_d",     32'(bus.D),     32'(pick(8'hFF, 8'h7F)));
        chk("clr_full_valid", 32'(bus.VALID), 32'h1);

        // CLR in the window-end cycle: no result
        ack_pulse();
        feed(255, 0, 1'b0);
        bus.CLR = 1'b1;
        bus.EN  = 1'b1;
        bus.S   = 1'b0;
        tick();
        bus.CLR = 1'b0;
        bus.EN  = 1'b0;
        chk("clr_end_valid", 32'(bus.VALID), 32'h0);
        chk("clr_end_d",     32'(bus.D),     32'(pick(8'hFF, 8'h7F)));

        // Window end with simultaneous ACK: VALID stays, no OVR
        feed(256, 0, 1'b0);
        chk("pre_sim_d",     32'(bus.D),     32'(pick(8'h00, 8'h80)));
        chk("pre_sim_valid", 32'(bus.VALID), 32'h1);
        feed(255, 1, 1'b0);
        bus.EN  = 1'b1;
        bus.S   = 1'b1;
        bus.ACK = 1'b1;
        tick();
        bus.EN  = 1'b0;
        bus.ACK = 1'b0;
        chk("sim_ack_d",     32'(bus.D),     32'(pick(8'hFF, 8'h7F)));
        chk("sim_ack_valid", 32'(bus.VALID), 32'h1);
        chk("sim_ack_ovr",   32'(bus.OVR),   32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
